// File: rtl/shadd_pkg.sv
// Shared types and helpers for the shared-adder round-robin arbiter.
package shadd_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    FULL = 1'b1
  } state_e;

  localparam int unsigned DEFAULT_DATA_W = 8;

  // Index width for n requesters; never narrower than one bit.
  function automatic int unsigned id_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/shadd_rr_arbiter_rr_pick.sv
// Combinational round-robin picker: first valid requester at or after ptr, wrapping.
module rr_pick #(
  parameter int unsigned N   = 4,
  parameter int unsigned IDW = 2
) (
  input  logic [N-1:0]   req_valid,
  input  logic [IDW-1:0] ptr,
  output logic [N-1:0]   grant,
  output logic [IDW-1:0] grant_idx,
  output logic           any_grant
);

  int unsigned idx;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any_grant = 1'b0;
    idx       = 0;
    for (int unsigned off = 0; off < N; off++) begin
      idx = 32'(ptr) + off;
      if (idx >= N) idx = idx - N;
      if (!any_grant && req_valid[IDW'(idx)]) begin
        any_grant             = 1'b1;
        grant[IDW'(idx)]      = 1'b1;
        grant_idx             = IDW'(idx);
      end
    end
  end

endmodule

// File: rtl/shadd_rr_arbiter.sv
// Round-robin arbiter sharing one registered adder between NUM_REQ requesters.
// Build option: define SHADD_SAT_EN for a saturating (unsigned) sum.
module shadd_rr_arbiter
  import shadd_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned DATA_W  = DEFAULT_DATA_W,
  localparam int unsigned ID_W   = id_width(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*DATA_W-1:0] req_a,
  input  logic [NUM_REQ*DATA_W-1:0] req_b,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [DATA_W-1:0]         rsp_sum,
  output logic                      rsp_carry,
  output logic [ID_W-1:0]           rsp_id
);

  state_e             state_q;
  state_e             state_d;
  logic [ID_W-1:0]    ptr_q;
  logic [ID_W-1:0]    ptr_d;
  logic [NUM_REQ-1:0] grant;
  logic [ID_W-1:0]    grant_idx;
  logic               any_grant;
  logic               can_accept;
  logic               accept;

  logic [DATA_W-1:0]  a_arr [NUM_REQ];
  logic [DATA_W-1:0]  b_arr [NUM_REQ];
  logic [DATA_W-1:0]  a_sel;
  logic [DATA_W-1:0]  b_sel;
  logic [DATA_W:0]    sum_full;
  logic [DATA_W-1:0]  sum_res;

  for (genvar k = 0; k < NUM_REQ; k++) begin : g_unpack
    assign a_arr[k] = req_a[k*DATA_W +: DATA_W];
    assign b_arr[k] = req_b[k*DATA_W +: DATA_W];
  end

  rr_pick #(
    .N   (NUM_REQ),
    .IDW (ID_W)
  ) u_pick (
    .req_valid (req_valid),
    .ptr       (ptr_q),
    .grant     (grant),
    .grant_idx (grant_idx),
    .any_grant (any_grant)
  );

  // Shared adder on the granted operand pair.
  assign a_sel    = a_arr[grant_idx];
  assign b_sel    = b_arr[grant_idx];
  assign sum_full = {1'b0, a_sel} + {1'b0, b_sel};

`ifdef SHADD_SAT_EN
  assign sum_res = sum_full[DATA_W] ? '1 : sum_full[DATA_W-1:0];
`else
  assign sum_res = sum_full[DATA_W-1:0];
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; a simultaneous drain and accept keeps the slot FULL.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = FULL;
      FULL:    if (rsp_ready && !accept) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Handshake and pointer update; req_ready held low during reset.
  always_comb begin
    can_accept = 1'b0;
    accept     = 1'b0;
    req_ready  = '0;
    ptr_d      = ptr_q;
    can_accept = (state_q == IDLE) || rsp_ready;
    accept     = can_accept && any_grant && rst_n;
    if (can_accept && rst_n) req_ready = grant;
    if (accept) begin
      if (grant_idx == ID_W'(NUM_REQ - 1)) ptr_d = '0;
      else                                 ptr_d = grant_idx + ID_W'(1);
    end
  end

  // Result and pointer registers; data holds its last value after a drain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_sum   <= '0;
      rsp_carry <= 1'b0;
      rsp_id    <= '0;
      ptr_q     <= '0;
    end else if (accept) begin
      rsp_sum   <= sum_res;
      rsp_carry <= sum_full[DATA_W];
      rsp_id    <= grant_idx;
      ptr_q     <= ptr_d;
    end
  end

  assign rsp_valid = (state_q == FULL);

endmodule

// File: tb/tb_shadd_rr_arbiter.sv
// Directed self-checking bench for shadd_rr_arbiter (NUM_REQ=4, DATA_W=8).
module tb_shadd_rr_arbiter;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [7:0]  rsp_sum;
  logic        rsp_carry;
  logic [1:0]  rsp_id;

  int tests;
  int fails;

  // Hand-computed results for the back-to-back operand set.
  logic [7:0] exp_sum   [4];
  logic       exp_carry [4];

  shadd_rr_arbiter #(.NUM_REQ(4), .DATA_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_sum   (rsp_sum),
    .rsp_carry (rsp_carry),
    .rsp_id    (rsp_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic set_ops(input int k, input logic [7:0] a, input logic [7:0] b);
    req_a[k*8 +: 8] = a;
    req_b[k*8 +: 8] = b;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req_valid = 4'b1111; rsp_ready = 1'b1;
    req_a = '0; req_b = '0;
    #2;
    tests++; if (rsp_valid !== 1'b0) begin fails++; $display("FAIL reset_valid got %b want 0", rsp_valid); end
    tests++; if (rsp_sum !== 8'h00) begin fails++; $display("FAIL reset_sum got %h want 00", rsp_sum); end
    tests++; if (rsp_carry !== 1'b0) begin fails++; $display("FAIL reset_carry got %b want 0", rsp_carry); end
    tests++; if (rsp_id !== 2'd0) begin fails++; $display("FAIL reset_id got %0d want 0", rsp_id); end
    tests++; if (req_ready !== 4'b0000) begin fails++; $display("FAIL reset_ready got %b want 0000", req_ready); end
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1; req_valid = 4'b0000;
  endtask

  task automatic test_single();
    set_ops(0, 8'h5A, 8'h3C);
    req_valid = 4'b0001; rsp_ready = 1'b1;
    #1;
    tests++; if (req_ready !== 4'b0001) begin fails++; $display("FAIL single_ready got %b want 0001", req_ready); end
    @(posedge clk); #1; req_valid = 4'b0000;
    tests++; if (rsp_valid !== 1'b1) begin fails++; $display("FAIL single_valid got %b want 1", rsp_valid); end
    tests++; if (rsp_sum !== 8'h96) begin fails++; $display("FAIL single_sum got %h want 96", rsp_sum); end
    tests++; if (rsp_carry !== 1'b0) begin fails++; $display("FAIL single_carry got %b want 0", rsp_carry); end
    tests++; if (rsp_id !== 2'd0) begin fails++; $display("FAIL single_id got %0d want 0", rsp_id); end
    @(posedge clk); #1;
    tests++; if (rsp_valid !== 1'b0) begin fails++; $display("FAIL drain_valid got %b want 0", rsp_valid); end
    tests++; if (rsp_sum !== 8'h96) begin fails++; $display("FAIL drain_sum_held got %h want 96", rsp_sum); end
  endtask

  task automatic test_carry();
    logic [7:0] want;
`ifdef SHADD_SAT_EN
    want = 8'hFF;
`else
    want = 8'h10;
`endif
    set_ops(2, 8'hF0, 8'h20);
    req_valid = 4'b0100;
    #1;
    tests++; if (req_ready !== 4'b0100) begin fails++; $display("FAIL carry_ready got %b want 0100", req_ready); end
    @(posedge clk); #1; req_valid = 4'b0000;
    tests++; if (rsp_sum !== want) begin fails++; $display("FAIL carry_sum got %h want %h", rsp_sum, want); end
    tests++; if (rsp_carry !== 1'b1) begin fails++; $display("FAIL carry_flag got %b want 1", rsp_carry); end
    tests++; if (rsp_id !== 2'd2) begin fails++; $display("FAIL carry_id got %0d want 2", rsp_id); end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    logic [3:0] exp_rdy;
    int k;
    rst_n = 1'b0; #1; rst_n = 1'b1;
    set_ops(0, 8'h01, 8'h02);
    set_ops(1, 8'h80, 8'h80);
    set_ops(2, 8'h7F, 8'h01);
    set_ops(3, 8'hFF, 8'hFF);
    exp_sum[0] = 8'h03; exp_carry[0] = 1'b0;
    exp_carry[1] = 1'b1; exp_sum[2] = 8'h80; exp_carry[2] = 1'b0; exp_carry[3] = 1'b1;
`ifdef SHADD_SAT_EN
    exp_sum[1] = 8'hFF; exp_sum[3] = 8'hFF;
`else
    exp_sum[1] = 8'h00; exp_sum[3] = 8'hFE;
`endif
    req_valid = 4'b1111; rsp_ready = 1'b1;
    #1;
    for (int i = 0; i < 5; i++) begin
      k = i % 4;
      exp_rdy = 4'b0001 << k;
      tests++; if (req_ready !== exp_rdy) begin fails++; $display("FAIL b2b_ready[%0d] got %b want %b", i, req_ready, exp_rdy); end
      @(posedge clk); #1;
      tests++; if (rsp_valid !== 1'b1) begin fails++; $display("FAIL b2b_valid[%0d] got %b want 1", i, rsp_valid); end
      tests++; if (rsp_id !== 2'(k)) begin fails++; $display("FAIL b2b_id[%0d] got %0d want %0d", i, rsp_id, k); end
      tests++; if ({rsp_carry, rsp_sum} !== {exp_carry[k], exp_sum[k]}) begin
        fails++; $display("FAIL b2b_sum[%0d] got %b/%h want %b/%h", i, rsp_carry, rsp_sum, exp_carry[k], exp_sum[k]);
      end
    end
  endtask

  task automatic test_backpressure();
    rsp_ready = 1'b0;
    #1;
    tests++; if (req_ready !== 4'b0000) begin fails++; $display("FAIL bp_ready0 got %b want 0000", req_ready); end
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      tests++; if (req_ready !== 4'b0000) begin fails++; $display("FAIL bp_ready[%0d] got %b want 0000", i, req_ready); end
      tests++; if (rsp_valid !== 1'b1) begin fails++; $display("FAIL bp_valid[%0d] got %b want 1", i, rsp_valid); end
      tests++; if ({rsp_carry, rsp_sum, rsp_id} !== {1'b0, 8'h03, 2'd0}) begin
        fails++; $display("FAIL bp_hold[%0d] got %b/%h/%0d want 0/03/0", i, rsp_carry, rsp_sum, rsp_id);
      end
    end
    rsp_ready = 1'b1;
    #1;
    tests++; if (req_ready !== 4'b0010) begin fails++; $display("FAIL bp_release_ready got %b want 0010", req_ready); end
    @(posedge clk); #1;
    tests++; if (rsp_valid !== 1'b1) begin fails++; $display("FAIL bp_release_valid got %b want 1", rsp_valid); end
    tests++; if (rsp_id !== 2'd1) begin fails++; $display("FAIL bp_release_id got %0d want 1", rsp_id); end
    req_valid = 4'b0000;
    @(posedge clk); #1;
    tests++; if (rsp_valid !== 1'b0) begin fails++; $display("FAIL bp_drain got %b want 0", rsp_valid); end
  endtask

  task automatic test_wrap();
    req_valid = 4'b0100;
    #1;
    tests++; if (req_ready !== 4'b0100) begin fails++; $display("FAIL wrap_g2 got %b want 0100", req_ready); end
    @(posedge clk); #1;
    req_valid = 4'b0110;
    tests++; if (rsp_id !== 2'd2) begin fails++; $display("FAIL wrap_id2 got %0d want 2", rsp_id); end
    #1;
    tests++; if (req_ready !== 4'b0010) begin fails++; $display("FAIL wrap_g1 got %b want 0010", req_ready); end
    @(posedge clk); #1;
    tests++; if (rsp_id !== 2'd1) begin fails++; $display("FAIL wrap_id1 got %0d want 1", rsp_id); end
    tests++; if (req_ready !== 4'b0100) begin fails++; $display("FAIL wrap_g2b got %b want 0100", req_ready); end
    @(posedge clk); #1;
    req_valid = 4'b0000;
    tests++; if (rsp_id !== 2'd2) begin fails++; $display("FAIL wrap_id2b got %0d want 2", rsp_id); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    req_valid = 4'b0001; rsp_ready = 1'b0;
    #1;
    tests++; if (req_ready !== 4'b0001) begin fails++; $display("FAIL mid_ready got %b want 0001", req_ready); end
    @(posedge clk); #1;
    req_valid = 4'b1010;
    tests++; if (rsp_valid !== 1'b1) begin fails++; $display("FAIL mid_pending got %b want 1", rsp_valid); end
    #2; rst_n = 1'b0;
    #1;
    tests++; if (rsp_valid !== 1'b0) begin fails++; $display("FAIL mid_async_valid got %b want 0", rsp_valid); end
    tests++; if (req_ready !== 4'b0000) begin fails++; $display("FAIL mid_rst_ready got %b want 0000", req_ready); end
    #1; rst_n = 1'b1; rsp_ready = 1'b1;
    #1;
    tests++; if (req_ready !== 4'b0010) begin fails++; $display("FAIL mid_after_ready got %b want 0010", req_ready); end
    @(posedge clk); #1;
    req_valid = 4'b0000;
    tests++; if ({rsp_valid, rsp_id} !== {1'b1, 2'd1}) begin
      fails++; $display("FAIL mid_after_rsp got %b/%0d want 1/1", rsp_valid, rsp_id);
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    test_reset();
    test_single();
    test_carry();
    test_back_to_back();
    test_backpressure();
    test_wrap();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/shadd_rr_arbiter.md
Name: shadd_rr_arbiter

Overview:
Round-robin arbiter sharing a single DATA_W-bit adder between NUM_REQ requesters.
- Each requester presents operands with a valid/ready handshake.
- The granted pair is added and registered; the result is returned with the requester ID on a single valid/ready response channel.
- Sits between the control blocks issuing arithmetic and the shared adder datapath, so those blocks do not each need their own adder.

Parameters:
NUM_REQ, 4, number of requesters (>=1)
DATA_W, 8, operand/result width
ID_W, (NUM_REQ>1 ? $clog2(NUM_REQ) : 1), requester ID width (localparam)

Ports:
clk  in  1  clock; all logic on posedge
rst_n  in  1  reset; one clock, reset is asynchronous and active-low
req_valid  in  NUM_REQ  per-requester operand valid
req_ready  out  NUM_REQ  per-requester grant/accept, one-hot or zero
req_a  in  NUM_REQ*DATA_W  operand A, requester k at bits [k*DATA_W +: DATA_W]
req_b  in  NUM_REQ*DATA_W  operand B, same packing
rsp_valid  out  1  result valid
rsp_ready  in  1  result consumer ready
rsp_sum  out  DATA_W  sum
rsp_carry  out  1  carry-out of sum
rsp_id  out  ID_W  index of requester that issued this result

Behaviour:
- Reset state, asynchronous on rst_n low: rsp_valid=0, rsp_sum=0, rsp_carry=0, rsp_id=0, RR pointer=0, FSM=IDLE.
- req_ready is forced to 0 while rst_n is low.
- FSM has two states:
  - IDLE: result register empty.
  - FULL: result held, rsp_valid=1.
- can_accept = (state==IDLE) | rsp_ready.
- req_ready[k] = can_accept & grant[k]. req_ready is combinational from req_valid, the pointer and the state.
- Grant selection: the first k with req_valid[k]=1, searching ptr, ptr+1, …, NUM_REQ-1, 0, …, ptr-1.
- Handshake: requester k is accepted when req_valid[k] & req_ready[k]. At most one acceptance per cycle.
- On acceptance:
  - {rsp_carry, rsp_sum} <= req_a[k] + req_b[k], computed at DATA_W+1 bits.
  - rsp_id <= k.
  - ptr <= (k+1) mod NUM_REQ.
  - state <= FULL.
- Latency: exactly 1 cycle from acceptance to rsp_valid.
- Throughput: 1 result/cycle when rsp_ready is held high.
- FULL & rsp_ready & no new acceptance -> IDLE, rsp_valid <= 0. The data registers keep their last value.
- FULL & rsp_ready & new acceptance (simultaneous) -> stay FULL; result registers replaced with the new result.
- FULL & !rsp_ready: no grant, all req_ready=0; rsp_sum/rsp_carry/rsp_id held stable.
- No req_valid asserted: ptr unchanged, no state change except response drain.
- A requester may deassert req_valid before being granted; no penalty or state is kept.
- Pointer wraps NUM_REQ-1 -> 0.
- NUM_REQ=1: always grants 0, ptr constant 0.
- Reset mid-operation: any pending result is discarded with no response issued; ptr returns to 0.

Optional Feature:
SHADD_SAT_EN
- Defined: on carry-out, rsp_sum = all-ones (saturating unsigned add). rsp_carry still reports the true carry.
- Undefined: rsp_sum is the modular (wrapping) low DATA_W bits.
- Ports are identical in both builds.

Decomposition:
- Package shadd_pkg:
  - state_e enum {IDLE, FULL}
  - default DATA_W constant
  - function id_width(n)
- Sub-module rr_pick: purely combinational. Inputs req_valid and ptr; outputs one-hot grant, grant index, any_grant. Reused by later arbiters.
- Adder, FSM and result registers live in the top module.

Test Plan:
- Only req_valid[0]=1, a=8'h5A, b=8'h3C, rsp_ready=1 -> req_ready=4'b0001 that cycle; next cycle rsp_valid=1, rsp_sum=8'h96, rsp_carry=0, rsp_id=0.
- req2 a=8'hF0, b=8'h20 -> rsp_sum=8'h10, rsp_carry=1. With SHADD_SAT_EN: rsp_sum=8'hFF, rsp_carry=1.
- All four req_valid held high, rsp_ready=1 -> grants 0,1,2,3,0 on consecutive cycles; rsp_id sequence 0,1,2,3,0 with no bubbles.
- Result pending, rsp_ready=0 for 3 cycles -> req_ready=0000 and rsp_* stable for those 3 cycles. When rsp_ready rises, the next requester is granted in the same cycle and rsp_valid stays 1.
- Pointer wrap: after a grant to 2 (ptr=3), req_valid=4'b0110 -> requester 1 granted next (search 3, 0, 1). Then req_valid=4'b0110 again -> requester 2 granted.
- rst_n pulsed low while rsp_valid=1 -> rsp_valid drops immediately (asynchronous), no handshake needed. After release with req_valid=4'b1010 -> requester 1 granted first (ptr=0).
